// File: rtl/sad_eval_pkg.sv
// Shared types and width helpers for the SAD error-sweep controller.
//   state_t        : sweep controller states
//   LAT_MAX        : largest supported core pipeline latency
//   CNT_W / SUM_W  : statistic widths for the default kernel size
//   cnt_w / sum_w  : the same widths for an arbitrary kernel size
package sad_eval_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StSweep,
    StDrain,
    StDone
  } state_t;

  localparam int unsigned LAT_MAX   = 7;
  localparam int unsigned N_IN_DEF  = 10;
  localparam int unsigned N_OUT_DEF = 3;

  // Mismatch counter must hold 2^N_IN; error sum must hold 2^N_IN * (2^N_OUT - 1).
  localparam int unsigned CNT_W = N_IN_DEF + 1;
  localparam int unsigned SUM_W = N_IN_DEF + N_OUT_DEF;

  function automatic int unsigned cnt_w(input int unsigned n_in);
    return n_in + 1;
  endfunction

  function automatic int unsigned sum_w(input int unsigned n_in, input int unsigned n_out);
    return n_in + n_out;
  endfunction

endpackage

// File: rtl/sad_err_acc.sv
// Error statistics accumulator: absolute difference of exact and approximate
// kernel results, folded into mismatch count, maximum and sum.
//   clk_i      : clock
//   rst_i      : synchronous active-high reset
//   clr_i      : clear all statistics (start of a new sweep)
//   vld_i      : current exact_i/approx_i pair belongs to the sweep
//   exact_i    : exact core result
//   approx_i   : approximate core result
//   err_cnt_o  : number of accumulated pairs with a nonzero difference
//   max_err_o  : largest absolute difference seen
//   sum_err_o  : sum of absolute differences
module sad_err_acc
  import sad_eval_pkg::*;
#(
  parameter int unsigned N_IN  = N_IN_DEF,
  parameter int unsigned N_OUT = N_OUT_DEF
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             clr_i,
  input  logic                             vld_i,
  input  logic [N_OUT-1:0]                 exact_i,
  input  logic [N_OUT-1:0]                 approx_i,
  output logic [cnt_w(N_IN)-1:0]           err_cnt_o,
  output logic [N_OUT-1:0]                 max_err_o,
  output logic [sum_w(N_IN, N_OUT)-1:0]    sum_err_o
);

  localparam int unsigned CntW = cnt_w(N_IN);
  localparam int unsigned SumW = sum_w(N_IN, N_OUT);

  logic [N_OUT-1:0] diff;
  logic [CntW-1:0]  err_cnt_q;
  logic [N_OUT-1:0] max_err_q;
  logic [SumW-1:0]  sum_err_q;

  always_comb begin
    diff = (exact_i >= approx_i) ? (exact_i - approx_i) : (approx_i - exact_i);
  end

  // Widths cover the worst case, so no saturation is needed.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      err_cnt_q <= '0;
      max_err_q <= '0;
      sum_err_q <= '0;
    end else if (vld_i) begin
      err_cnt_q <= err_cnt_q + CntW'(diff != '0);
      if (diff > max_err_q) begin
        max_err_q <= diff;
      end
      sum_err_q <= sum_err_q + SumW'(diff);
    end
  end

  assign err_cnt_o = err_cnt_q;
  assign max_err_o = max_err_q;
  assign sum_err_o = sum_err_q;

endmodule

// File: rtl/sad_err_sweep.sv
// Exhaustive error-evaluation sequencer. Sweeps every N_IN-bit vector, one per
// cycle, into an external exact and approximate core and accumulates the
// error statistics of their LAT-cycle-delayed results.
//   clk      : clock, rising edge
//   rst      : synchronous active-high reset
//   start    : begin a sweep (accepted in idle or in the done cycle)
//   abort    : cancel a running sweep, no done pulse
//   busy     : sweep or drain in progress
//   done     : one-cycle pulse, statistics final
//   vec_o    : vector driven to both cores
//   exact_i  : exact core result
//   approx_i : approximate core result
//   err_cnt  : vectors with exact != approx
//   max_err  : maximum |exact - approx|
//   sum_err  : sum of |exact - approx|
module sad_err_sweep
  import sad_eval_pkg::*;
#(
  parameter int unsigned N_IN  = N_IN_DEF,
  parameter int unsigned N_OUT = N_OUT_DEF,
  parameter int unsigned LAT   = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          abort,
  output logic                          busy,
  output logic                          done,
  output logic [N_IN-1:0]               vec_o,
  input  logic [N_OUT-1:0]              exact_i,
  input  logic [N_OUT-1:0]              approx_i,
  output logic [cnt_w(N_IN)-1:0]        err_cnt,
  output logic [N_OUT-1:0]              max_err,
  output logic [sum_w(N_IN, N_OUT)-1:0] sum_err
);

  localparam logic [N_IN-1:0] VecLast  = '1;
  localparam logic [LAT:0]    VldFirst = (LAT + 1)'(1);

  state_t          state_q;
  logic [N_IN-1:0] vec_q;
  logic [LAT:0]    vld_q;
  logic [LAT:0]    vld_adv;
  logic            busy_q;
  logic            done_q;
  logic            start_ok;
  logic            issue;

  // vld_q[i] marks that the core output i+1 cycles after issue is a sweep result;
  // vld_q[LAT] therefore lines up with exact_i/approx_i of a valid vector.
  always_comb begin
    start_ok   = start && ((state_q == StIdle) || (state_q == StDone));
    issue      = start_ok || ((state_q == StSweep) && (vec_q != VecLast) && !abort);
    vld_adv    = '0;
    vld_adv[0] = issue;
    for (int i = 1; i <= int'(LAT); i++) begin
      vld_adv[i] = vld_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      vec_q   <= '0;
      vld_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle, StDone: begin
          if (start_ok) begin
            state_q <= StSweep;
            vec_q   <= '0;
            vld_q   <= VldFirst;
            busy_q  <= 1'b1;
          end else begin
            state_q <= StIdle;
          end
        end
        StSweep: begin
          if (abort) begin
            state_q <= StIdle;
            vld_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            vld_q <= vld_adv;
            if (vec_q != VecLast) begin
              vec_q <= vec_q + N_IN'(1);
            end else if (vld_adv == '0) begin
              // Zero-latency cores: nothing left in flight, skip the drain.
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q <= StDrain;
            end
          end
        end
        StDrain: begin
          if (abort) begin
            state_q <= StIdle;
            vld_q   <= '0;
            busy_q  <= 1'b0;
          end else begin
            vld_q <= vld_adv;
            if (vld_adv == '0) begin
              state_q <= StDone;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  sad_err_acc #(
    .N_IN  (N_IN),
    .N_OUT (N_OUT)
  ) u_acc (
    .clk_i     (clk),
    .rst_i     (rst),
    .clr_i     (start_ok),
    .vld_i     (vld_q[LAT]),
    .exact_i   (exact_i),
    .approx_i  (approx_i),
    .err_cnt_o (err_cnt),
    .max_err_o (max_err),
    .sum_err_o (sum_err)
  );

  assign busy  = busy_q;
  assign done  = done_q;
  assign vec_o = vec_q;

endmodule

// File: tb/tb_sad_err_sweep.sv
// Bench for sad_err_sweep: a zero-latency instance and a LAT=2 instance, each
// driven by behavioural cores; expected statistics are pushed when a sweep is
// started and popped when done is observed.
module tb_sad_err_sweep;

  localparam int NI = 10;
  localparam int NO = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, start, abort, sel;
  int   mode;

  logic          busy_a, done_a, busy_b, done_b;
  logic [NI-1:0] vec_a, vec_b;
  logic [NO-1:0] exact_a, approx_a, exact_b, approx_b;
  logic [NI:0]   err_a, err_b;
  logic [NO-1:0] max_a, max_b;
  logic [NI+NO-1:0] sum_a, sum_b;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int err;
    int mx;
    int sum;
    int done_at;
    int busy_len;
  } exp_t;

  exp_t sb[$];

  function automatic logic [2:0] popcnt7(input logic [NI-1:0] v);
    logic [2:0] c;
    c = '0;
    for (int i = 0; i < 7; i++) c = c + {2'b00, v[i]};
    return c;
  endfunction

  function automatic logic [2:0] f_exact(input int m, input logic [NI-1:0] v);
    if (m == 0) return popcnt7(v);
    return v[2:0];
  endfunction

  function automatic logic [2:0] f_approx(input int m, input logic [NI-1:0] v);
    if (m == 0) return popcnt7(v);
    if (m == 1) return 3'd0;
    return v[5:3];
  endfunction

  // Zero-latency cores for instance A.
  assign exact_a  = f_exact(mode, vec_a);
  assign approx_a = f_approx(mode, vec_a);

  // Two-stage pipelined cores for instance B.
  logic [2:0] ex_b1, ex_b2, ap_b1, ap_b2;
  always @(posedge clk) begin
    ex_b1 <= f_exact(mode, vec_b);
    ex_b2 <= ex_b1;
    ap_b1 <= f_approx(mode, vec_b);
    ap_b2 <= ap_b1;
  end
  assign exact_b  = ex_b2;
  assign approx_b = ap_b2;

  sad_err_sweep #(.N_IN(NI), .N_OUT(NO), .LAT(0)) u_dut_a (
    .clk      (clk),
    .rst      (rst),
    .start    (start && !sel),
    .abort    (abort && !sel),
    .busy     (busy_a),
    .done     (done_a),
    .vec_o    (vec_a),
    .exact_i  (exact_a),
    .approx_i (approx_a),
    .err_cnt  (err_a),
    .max_err  (max_a),
    .sum_err  (sum_a)
  );

  sad_err_sweep #(.N_IN(NI), .N_OUT(NO), .LAT(2)) u_dut_b (
    .clk      (clk),
    .rst      (rst),
    .start    (start && sel),
    .abort    (abort && sel),
    .busy     (busy_b),
    .done     (done_b),
    .vec_o    (vec_b),
    .exact_i  (exact_b),
    .approx_i (approx_b),
    .err_cnt  (err_b),
    .max_err  (max_b),
    .sum_err  (sum_b)
  );

  logic          busy_s, done_s;
  logic [NI-1:0] vec_s;
  logic [NI:0]   err_s;
  logic [NO-1:0] max_s;
  logic [NI+NO-1:0] sum_s;
  assign busy_s = sel ? busy_b : busy_a;
  assign done_s = sel ? done_b : done_a;
  assign vec_s  = sel ? vec_b  : vec_a;
  assign err_s  = sel ? err_b  : err_a;
  assign max_s  = sel ? max_b  : max_a;
  assign sum_s  = sel ? sum_b  : sum_a;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", name, obs, expv);
    end
  endtask

  // Model of a full sweep for the current core mode and latency.
  task automatic push_exp(input int lat);
    exp_t e;
    e.err = 0;
    e.mx  = 0;
    e.sum = 0;
    for (int v = 0; v < (1 << NI); v++) begin
      int x, y, d;
      x = int'(f_exact(mode, NI'(v)));
      y = int'(f_approx(mode, NI'(v)));
      d = (x > y) ? (x - y) : (y - x);
      if (d != 0) e.err++;
      if (d > e.mx) e.mx = d;
      e.sum += d;
    end
    e.done_at  = (1 << NI) + lat + 1;
    e.busy_len = (1 << NI) + lat;
    sb.push_back(e);
  endtask

  // Called at a falling edge; start is sampled at the next rising edge.
  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Entered in the first cycle after start was sampled (cnt = 1).
  task automatic run_sweep(input string tag, input int poke_vec, input int abort_vec,
                           input int rst_vec, input bit restart);
    int   cnt;
    int   busy_cnt;
    int   limit;
    bit   quiet;
    exp_t e;
    cnt      = 1;
    busy_cnt = 0;
    limit    = (1 << NI) + 50;
    while (!done_s && cnt < limit) begin
      start = 1'b0;
      if (busy_s) busy_cnt++;
      if (busy_s && vec_s == poke_vec) start = 1'b1;
      if (busy_s && vec_s == abort_vec) begin
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check({tag, " busy after abort"}, busy_s, 0);
        check({tag, " done after abort"}, done_s, 0);
        quiet = 1'b1;
        repeat (20) begin
          @(negedge clk);
          if (done_s) quiet = 1'b0;
        end
        check({tag, " no done pulse after abort"}, quiet, 1);
        return;
      end
      if (busy_s && vec_s == rst_vec) begin
        rst = 1'b1;
        @(negedge clk);
        check({tag, " busy after reset"}, busy_s, 0);
        check({tag, " done after reset"}, done_s, 0);
        check({tag, " vec after reset"}, vec_s, 0);
        check({tag, " err_cnt after reset"}, err_s, 0);
        check({tag, " max_err after reset"}, max_s, 0);
        check({tag, " sum_err after reset"}, sum_s, 0);
        rst = 1'b0;
        @(negedge clk);
        return;
      end
      @(negedge clk);
      cnt++;
    end
    start = 1'b0;
    check({tag, " done seen"}, done_s, 1);
    check({tag, " scoreboard entry"}, sb.size() > 0, 1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check({tag, " done cycle"}, cnt, e.done_at);
    check({tag, " busy cycles"}, busy_cnt, e.busy_len);
    check({tag, " busy in done cycle"}, busy_s, 0);
    check({tag, " err_cnt"}, err_s, e.err);
    check({tag, " max_err"}, max_s, e.mx);
    check({tag, " sum_err"}, sum_s, e.sum);
    if (restart) begin
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check({tag, " restart vec"}, vec_s, 0);
      check({tag, " restart busy"}, busy_s, 1);
      check({tag, " restart done low"}, done_s, 0);
      check({tag, " restart err_cnt cleared"}, err_s, 0);
      check({tag, " restart max_err cleared"}, max_s, 0);
      check({tag, " restart sum_err cleared"}, sum_s, 0);
    end else begin
      @(negedge clk);
      check({tag, " done one cycle"}, done_s, 0);
      check({tag, " idle after done"}, busy_s, 0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    sel   = 1'b0;
    mode  = 0;
    repeat (3) @(negedge clk);
    check("reset busy a", busy_a, 0);
    check("reset done a", done_a, 0);
    check("reset vec a", vec_a, 0);
    check("reset err a", err_a, 0);
    check("reset max a", max_a, 0);
    check("reset sum a", sum_a, 0);
    check("reset busy b", busy_b, 0);
    check("reset done b", done_b, 0);
    check("reset vec b", vec_b, 0);
    check("reset err b", err_b, 0);
    check("reset max b", max_b, 0);
    check("reset sum b", sum_b, 0);
    rst = 1'b0;
    @(negedge clk);

    // Loopback, zero latency.
    sel = 1'b0; mode = 0;
    push_exp(0); pulse_start(); run_sweep("loopback", -1, -1, -1, 1'b0);

    // Stuck-zero approximation.
    mode = 1;
    push_exp(0); pulse_start(); run_sweep("stuck0", -1, -1, -1, 1'b0);

    // Mixed-error approximation.
    mode = 2;
    push_exp(0); pulse_start(); run_sweep("mixed", -1, -1, -1, 1'b0);

    // Pipelined cores.
    sel = 1'b1; mode = 1;
    push_exp(2); pulse_start(); run_sweep("lat2", -1, -1, -1, 1'b0);

    // Abort mid-sweep, then a clean sweep.
    sel = 1'b0; mode = 1;
    pulse_start(); run_sweep("abort", -1, 300, -1, 1'b0);
    push_exp(0); pulse_start(); run_sweep("after_abort", -1, -1, -1, 1'b0);

    // Ignored start mid-sweep, restart held in the done cycle.
    push_exp(0); push_exp(0);
    pulse_start(); run_sweep("ign_start", 10, -1, -1, 1'b1);
    run_sweep("restarted", -1, -1, -1, 1'b0);

    // Reset mid-sweep on the pipelined instance, then a clean sweep.
    sel = 1'b1; mode = 2;
    pulse_start(); run_sweep("reset", -1, -1, 512, 1'b0);
    push_exp(2); pulse_start(); run_sweep("after_reset", -1, -1, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sad_err_sweep.md
# sad_err_sweep

Exhaustive error-evaluation controller for the small SAD kernels in the approximate-logic flow. It sweeps every input vector of an `N_IN`-bit kernel, one per cycle, and drives the same vector to an exact core and an approximate core, both instantiated outside this block. It compares the two `N_OUT`-bit results and accumulates error statistics: mismatch count, maximum absolute error and sum of absolute errors. It is the sequencer that turns a combinational or pipelined SAD netlist into a single measured error figure.

## Interface
Parameters:
- `N_IN`, default 10: kernel input width; the sweep length is 2^N_IN vectors.
- `N_OUT`, default 3: kernel output width, unsigned.
- `LAT`, default 0: pipeline latency of both cores in cycles (0..7). It must be identical for both cores.

Ports:
- `clk`, in, 1: single clock. All logic is on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `start`, in, 1: single-cycle request to begin a sweep.
- `abort`, in, 1: cancels a running sweep.
- `busy`, out, 1: a sweep or drain is in progress.
- `done`, out, 1: one-cycle pulse; the statistics are final.
- `vec_o`, out, N_IN: vector driven to both cores (registered).
- `exact_i`, in, N_OUT: exact core result.
- `approx_i`, in, N_OUT: approximate core result.
- `err_cnt`, out, N_IN+1: number of vectors with exact ≠ approx.
- `max_err`, out, N_OUT: maximum |exact − approx|.
- `sum_err`, out, N_IN+N_OUT: sum of |exact − approx|.

## Operation
States: IDLE, SWEEP, DRAIN, DONE.
- **IDLE:**
  - `start`=1 → SWEEP.
  - On that same edge: `vec_o`←0, `err_cnt`/`max_err`/`sum_err`←0, sample-valid pipe cleared.
- **SWEEP:**
  - Each edge: `vec_o`←`vec_o`+1.
  - A valid token enters a `LAT`+1-deep valid pipe.
  - After the edge that issued vector 2^N_IN−1 → DRAIN. `vec_o` holds 2^N_IN−1 and never wraps to 0.
- **DRAIN:**
  - No new tokens are issued.
  - Remains until the valid pipe is empty, then → DONE.
  - With `LAT`=0, DRAIN lasts zero cycles and the block goes straight from SWEEP to DONE.
- **DONE:**
  - `done`=1 for exactly one cycle, `busy`=0.
  - Next state is IDLE, or SWEEP if `start`=1 in this cycle (restart with cleared statistics).

Accumulation, on every edge where the pipe-output token is valid:
- d = |exact_i − approx_i|, computed unsigned in N_OUT bits.
- `err_cnt` += (d≠0).
- `max_err` = max(`max_err`, d).
- `sum_err` += d.
- No saturation is needed: the widths cover the worst case, e.g. 1024·7 = 7168 < 2^13.

Other rules:
- `start` is ignored in SWEEP and DRAIN.
- `abort`=1 in SWEEP or DRAIN → IDLE on that edge:
  - the pipe is cleared and `done` is not pulsed;
  - statistics hold their partial values and are not valid.
- `abort` in IDLE or DONE has no effect.
- If `abort` and `start` are both high in DONE, `start` wins.
- Statistics hold after DONE until the next accepted `start`.
- `rst` overrides everything, including mid-sweep:
  - state=IDLE;
  - `busy`=0, `done`=0, `vec_o`=0;
  - `err_cnt`=0, `max_err`=0, `sum_err`=0;
  - valid pipe empty.

## Timing
- `start` is sampled at edge k.
- `busy`=1 from cycle k+1 through cycle k+2^N_IN+LAT.
- `vec_o`=v during cycle k+1+v.
- The result for v is accumulated at the edge that ends cycle k+1+v+LAT.
- `done` is high in cycle k+2^N_IN+LAT+1.
- Throughput is one vector per cycle with no bubbles.
- With the defaults, `done` arrives 1025 cycles after start.
- `busy` and `done` are never high together.
- Statistics are stable and final in the `done` cycle.

## Structure
- Package `sad_eval_pkg`:
  - `state_t` enum (IDLE, SWEEP, DRAIN, DONE);
  - width helper constants `CNT_W`=N_IN+1 and `SUM_W`=N_IN+N_OUT;
  - `LAT_MAX`=7.
- Sub-module `sad_err_acc`:
  - inputs: `exact_i`, `approx_i`, a valid strobe and a clear strobe;
  - contains the absolute-difference logic and the three accumulators;
  - instantiated once.
- The top level holds the FSM, the vector counter and the valid shift register.

## Test plan
- **Loopback** (approx=exact=popcount-style function, `LAT`=0): start → `done` at cycle k+1025, `err_cnt`=0, `max_err`=0, `sum_err`=0.
- **Stuck-zero approx** (exact=`vec_o`[2:0], approx=0): → `err_cnt`=896, `max_err`=7, `sum_err`=3584.
- **Pipelined cores** (`LAT`=2 delay model, stimulus as in the stuck-zero case): → `done` at k+1027, same statistics, `busy` high for 1026 cycles.
- **Abort** at `vec_o`=300: → `busy`=0 the next cycle, no `done` pulse. A following start gives the full correct statistics.
- **Ignored start and restart:** `start` pulsed at `vec_o`=10 is ignored; `start` held high in the `done` cycle → immediate restart with cleared statistics, `vec_o`=0 the next cycle.
- **Reset mid-sweep** (`rst` at `vec_o`=512): → all outputs 0 the next cycle, state IDLE. A subsequent sweep gives correct results.
